sc_max7219_driver: RTL and testbench
====================================

# sc_max7219_driver

Serial refresh engine for the 8x8 LED matrix: drives the MAX7219 three-wire interface (DIN, NCS, CLK) from the game frame. It sits directly downstream of the frame-row multiplexer in the top-level system. It presents a 3-bit row index, samples the 8-bit row pattern that comes back, and continuously rewrites the MAX7219 digit registers. At power-up it first configures the chip (shutdown off, no decode, scan limit 7, intensity, display test off).

## Interface
- `CLKDIV`, default 25: system cycles per half SPI clock period; 25 gives 1 MHz at 50 MHz. Legal range 2..255.
- `DATAWIDTH_BUS`, default 8: row width.
- `SC_MAX7219DRIVER_CLOCK_50`, input, 1 bit: system clock. Everything is synchronous to its rising edge.
- `SC_MAX7219DRIVER_RESET_InHigh`, input, 1 bit: synchronous, active-high reset.
- `SC_MAX7219DRIVER_dispData_InBUS`, input, 8 bits: row pattern for the row selected by `dispAddr`.
- `SC_MAX7219DRIVER_intensity_InBUS`, input, 4 bits: brightness code.
- `SC_MAX7219DRIVER_dispAddr_OutBUS`, output, 3 bits: row index being requested.
- `SC_MAX7219DRIVER_din_Out`, output, 1 bit: MAX7219 DIN.
- `SC_MAX7219DRIVER_ncs_Out`, output, 1 bit: MAX7219 LOAD/CS, active low.
- `SC_MAX7219DRIVER_sclk_Out`, output, 1 bit: MAX7219 CLK.
- `SC_MAX7219DRIVER_initDone_Out`, output, 1 bit: high once configuration is complete; stays high until reset.
- `SC_MAX7219DRIVER_frameDone_Out`, output, 1 bit: one-cycle pulse after the last word of each refresh frame latches.

## Operation
- **Word format:** 16 bits, sent MSB first, `{4'b0000, reg[3:0], data[7:0]}`.
- **Init sequence:** five words, sent once after reset, in this order:
  - 0x0C/0x01 (shutdown register: normal operation)
  - 0x09/0x00 (decode mode: none)
  - 0x0B/0x07 (scan limit: 7)
  - 0x0A/{4'h0, intensity}
  - 0x0F/0x00 (display test: off)
- **initDone** rises in the cycle after the fifth word's latch phase ends.
- **Refresh frame:** nine words, repeated forever.
  - Words k = 0..7 are reg 0x01+k with the data sampled for row k.
  - Word 8 is 0x0A/intensity, so brightness changes apply within one frame.
- **Row handshake:**
  - `dispAddr` is loaded with the index of the next digit word when the previous word enters LATCH.
  - `dispData` is sampled on the last cycle of LOAD, which is CLKDIV+1 cycles after the address change. A registered upstream mux is therefore tolerated.
  - During the intensity word and the init words, `dispAddr` holds its last value.
- **Intensity** is sampled in the LOAD state of each intensity word.
- **FSM states:**
  - LOAD (1 cycle): build the shift word, set NCS low, set DIN to the word MSB.
  - SETUP (CLKDIV cycles): NCS low, CLK low.
  - SCLK_LO (CLKDIV cycles): CLK low, DIN holds the current bit.
  - SCLK_HI (CLKDIV cycles): CLK high; at its end, shift left and decrement the bit counter. Go to SCLK_LO, or to LATCH after bit 0.
  - LATCH (CLKDIV cycles): CLK low, NCS high. The MAX7219 latches on the NCS rise. Then go to LOAD of the next word.
- **Counters:**
  - Bit counter 4 bits, 15 down to 0.
  - Word counter 0..4 in init. After init it counts 0..8 and wraps 8→0. The wrap produces the frameDone pulse in the cycle LATCH ends.
  - Half-period counter 8 bits, 0..CLKDIV-1.
- **Reset:**
  - Reset at any cycle returns to LOAD of init word 0 and clears all counters.
  - Forcing NCS high mid-word latches a partial word; this is accepted because the init sequence rewrites every control register and the following frame rewrites every digit.

## Timing
- **Reset values:** ncs=1, sclk=0, din=0, dispAddr=0, initDone=0, frameDone=0.
- **After reset release:** NCS falls on the first edge (LOAD), with reg value 0x0C.
- **Per word:** 1 + 34·CLKDIV cycles. With CLKDIV=25 this is 851 cycles (17.02 µs).
- **Per frame:** 9 words = 7659 cycles (153.18 µs). The first frameDone comes 5·851 + 7659 = 11914 cycles after reset release.
- **DIN setup:** DIN changes only while CLK is low, at least CLKDIV cycles before each rising edge, which meets MAX7219 tDS. CLK high time is CLKDIV cycles.
- **NCS:** high for CLKDIV cycles between words. No CLK rising edge occurs while NCS is high.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- **Shared package `max7219_pkg`:**
  - MAX7219 register address constants: DIGIT0=0x1, DECODE=0x9, INTENSITY=0xA, SCANLIMIT=0xB, SHUTDOWN=0xC, TEST=0xF.
  - The init word table.
  - The FSM state encoding.
- **Sub-module `sc_max7219_spitx`:** 16-bit shift, bit counter and half-period timer, with a start/busy/done handshake. The top FSM handles sequencing and row addressing.

## Test plan
- **Init sequence:** CLKDIV=2, reset for 3 cycles. Decode DIN on CLK rises, framed by NCS. Required words: 0x0C01, 0x0900, 0x0B07, 0x0A0A (intensity=4'hA), 0x0F00; initDone rises after the fifth.
- **Refresh frame:** upstream mux returns 0x10 for row 0 and 0x00 otherwise. Required frame words: 0x0110, 0x0200 … 0x0800, 0x0A0A. frameDone pulses for exactly 1 cycle after each frame.
- **Handshake latency:** upstream register adds 1 cycle of latency, with distinct patterns per row (0x80>>k). Each digit k+1 must carry 0x80>>k.
- **Intensity change:** intensity changes from 0xA to 0x3 mid-frame. The next intensity word must be 0x0A03, and the digit words are unchanged.
- **Reset mid-word:** assert reset at bit 7 of digit 4. On the next edge ncs=1 and sclk=0, and the following transfer is 0x0C01.
- **Timing checks with CLKDIV=25:** word length 851 cycles; DIN stable ≥25 cycles before every CLK rise; NCS high exactly 25 cycles between words.

Source files
------------

// File: rtl/max7219_pkg.sv
// MAX7219 register map, power-up configuration table and
// serial engine state encoding shared by the driver files.
package max7219_pkg;

  localparam logic [3:0] REG_DIGIT0    = 4'h1;
  localparam logic [3:0] REG_DECODE    = 4'h9;
  localparam logic [3:0] REG_INTENSITY = 4'hA;
  localparam logic [3:0] REG_SCANLIMIT = 4'hB;
  localparam logic [3:0] REG_SHUTDOWN  = 4'hC;
  localparam logic [3:0] REG_TEST      = 4'hF;

  localparam logic [3:0] INIT_LAST  = 4'd4;
  localparam logic [3:0] FRAME_LAST = 4'd8;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_SETUP,
    ST_SCLK_LO,
    ST_SCLK_HI,
    ST_LATCH
  } spi_state_e;

  function automatic logic [15:0] init_word(
    input logic [2:0] idx,
    input logic [3:0] inten
  );
    logic [15:0] w;
    case (idx)
      3'd0:    w = {4'h0, REG_SHUTDOWN, 8'h01};
      3'd1:    w = {4'h0, REG_DECODE, 8'h00};
      3'd2:    w = {4'h0, REG_SCANLIMIT, 8'h07};
      3'd3:    w = {4'h0, REG_INTENSITY, 4'h0, inten};
      default: w = {4'h0, REG_TEST, 8'h00};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/sc_max7219_spitx.sv
// One 16-bit MAX7219 transfer: LOAD, SETUP, 16 clock periods,
// then LATCH with NCS high. All pin outputs come straight from flops.
module sc_max7219_spitx
  import max7219_pkg::*;
#(
  parameter int CLKDIV = 25
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [15:0] word_i,
  output logic        busy_o,
  output logic        latch_o,
  output logic        done_o,
  output logic        din_o,
  output logic        ncs_o,
  output logic        sclk_o
);

  localparam logic [7:0] HMAX = 8'(CLKDIV - 1);

  spi_state_e  state_q, state_d;
  logic [7:0]  hcnt_q, hcnt_d;
  logic [3:0]  bcnt_q, bcnt_d;
  logic [15:0] shift_q, shift_d;
  logic        ncs_q, ncs_d;
  logic        sclk_q, sclk_d;
  logic        hend;

  assign hend = (hcnt_q == HMAX);

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q + 8'd1;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    latch_o = 1'b0;
    done_o  = 1'b0;
    unique case (state_q)
      ST_LOAD: begin
        hcnt_d = 8'd0;
        if (start_i) begin
          shift_d = word_i;
          bcnt_d  = 4'd15;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (hend) begin
          hcnt_d  = 8'd0;
          state_d = ST_SCLK_LO;
        end
      end
      ST_SCLK_LO: begin
        if (hend) begin
          hcnt_d  = 8'd0;
          state_d = ST_SCLK_HI;
        end
      end
      ST_SCLK_HI: begin
        if (hend) begin
          hcnt_d  = 8'd0;
          shift_d = {shift_q[14:0], 1'b0};
          bcnt_d  = bcnt_q - 4'd1;
          if (bcnt_q == 4'd0) begin
            state_d = ST_LATCH;
            latch_o = 1'b1;
          end else begin
            state_d = ST_SCLK_LO;
          end
        end
      end
      ST_LATCH: begin
        if (hend) begin
          hcnt_d  = 8'd0;
          done_o  = 1'b1;
          state_d = ST_LOAD;
        end
      end
      default: state_d = ST_LOAD;
    endcase
    // Pins follow the state being entered so they change on the same edge.
    ncs_d  = (state_d == ST_LATCH);
    sclk_d = (state_d == ST_SCLK_HI);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_LOAD;
      hcnt_q  <= 8'd0;
      bcnt_q  <= 4'd0;
      shift_q <= 16'd0;
      ncs_q   <= 1'b1;
      sclk_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      ncs_q   <= ncs_d;
      sclk_q  <= sclk_d;
    end
  end

  assign busy_o = (state_q != ST_LOAD);
  assign din_o  = shift_q[15];
  assign ncs_o  = ncs_q;
  assign sclk_o = sclk_q;

endmodule

// File: rtl/sc_max7219_driver.sv
// MAX7219 refresh engine: configures the chip after reset, then
// rewrites all eight digits plus intensity forever.
module sc_max7219_driver
  import max7219_pkg::*;
#(
  parameter int CLKDIV        = 25,
  parameter int DATAWIDTH_BUS = 8
) (
  input  logic                     SC_MAX7219DRIVER_CLOCK_50,
  input  logic                     SC_MAX7219DRIVER_RESET_InHigh,
  input  logic [DATAWIDTH_BUS-1:0] SC_MAX7219DRIVER_dispData_InBUS,
  input  logic [3:0]               SC_MAX7219DRIVER_intensity_InBUS,
  output logic [2:0]               SC_MAX7219DRIVER_dispAddr_OutBUS,
  output logic                     SC_MAX7219DRIVER_din_Out,
  output logic                     SC_MAX7219DRIVER_ncs_Out,
  output logic                     SC_MAX7219DRIVER_sclk_Out,
  output logic                     SC_MAX7219DRIVER_initDone_Out,
  output logic                     SC_MAX7219DRIVER_frameDone_Out
);

  logic        init_done_q, init_done_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [2:0]  addr_q, addr_d;
  logic        frame_done_q, frame_done_d;
  logic [15:0] word;
  logic [7:0]  row;
  logic        busy, latch, done;

  assign row = 8'(SC_MAX7219DRIVER_dispData_InBUS);

  always_comb begin
    if (!init_done_q) begin
      word = init_word(wcnt_q[2:0], SC_MAX7219DRIVER_intensity_InBUS);
    end else if (wcnt_q == FRAME_LAST) begin
      word = {4'h0, REG_INTENSITY, 4'h0, SC_MAX7219DRIVER_intensity_InBUS};
    end else begin
      word = {4'h0, REG_DIGIT0 + wcnt_q, row};
    end
  end

  always_comb begin
    init_done_d  = init_done_q;
    wcnt_d       = wcnt_q;
    addr_d       = addr_q;
    frame_done_d = 1'b0;
    // Request the next digit row early so a registered mux has time.
    if (latch) begin
      if (!init_done_q) begin
        if (wcnt_q == INIT_LAST) addr_d = 3'd0;
      end else if (wcnt_q == FRAME_LAST) begin
        addr_d = 3'd0;
      end else if (wcnt_q < 4'd7) begin
        addr_d = 3'(wcnt_q + 4'd1);
      end
    end
    if (done) begin
      if (!init_done_q) begin
        if (wcnt_q == INIT_LAST) begin
          init_done_d = 1'b1;
          wcnt_d      = 4'd0;
        end else begin
          wcnt_d = wcnt_q + 4'd1;
        end
      end else if (wcnt_q == FRAME_LAST) begin
        wcnt_d       = 4'd0;
        frame_done_d = 1'b1;
      end else begin
        wcnt_d = wcnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge SC_MAX7219DRIVER_CLOCK_50) begin
    if (SC_MAX7219DRIVER_RESET_InHigh) begin
      init_done_q  <= 1'b0;
      wcnt_q       <= 4'd0;
      addr_q       <= 3'd0;
      frame_done_q <= 1'b0;
    end else begin
      init_done_q  <= init_done_d;
      wcnt_q       <= wcnt_d;
      addr_q       <= addr_d;
      frame_done_q <= frame_done_d;
    end
  end

  sc_max7219_spitx #(
    .CLKDIV(CLKDIV)
  ) u_spitx (
    .clk_i   (SC_MAX7219DRIVER_CLOCK_50),
    .rst_i   (SC_MAX7219DRIVER_RESET_InHigh),
    .start_i (~busy),
    .word_i  (word),
    .busy_o  (busy),
    .latch_o (latch),
    .done_o  (done),
    .din_o   (SC_MAX7219DRIVER_din_Out),
    .ncs_o   (SC_MAX7219DRIVER_ncs_Out),
    .sclk_o  (SC_MAX7219DRIVER_sclk_Out)
  );

  assign SC_MAX7219DRIVER_dispAddr_OutBUS = addr_q;
  assign SC_MAX7219DRIVER_initDone_Out    = init_done_q;
  assign SC_MAX7219DRIVER_frameDone_Out   = frame_done_q;

endmodule

// File: tb/tb_sc_max7219_driver.sv
// Bench for sc_max7219_driver: decodes the serial stream into
// words and compares against expected words queued by each test.
module tb_sc_max7219_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic [3:0] inten = 4'hA;
  logic [2:0] addr;
  logic       din, ncs, sclk, idone, fdone;
  logic [7:0] data, data_reg;
  int         pat_sel = 0;
  bit         reg_mode = 1'b0;

  logic       rst25 = 1'b1;
  logic [2:0] addr25;
  logic       din25, ncs25, sclk25, idone25, fd25;

  int checks = 0;
  int errors = 0;

  logic [15:0] got_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] sh = 16'd0;
  int          nb = 0;

  function automatic logic [7:0] row_pat(int p, logic [2:0] k);
    if (p == 0) return (k == 3'd0) ? 8'h10 : 8'h00;
    return 8'h80 >> k;
  endfunction

  always @(posedge clk) data_reg <= row_pat(pat_sel, addr);
  assign data = reg_mode ? data_reg : row_pat(pat_sel, addr);

  sc_max7219_driver #(.CLKDIV(2), .DATAWIDTH_BUS(8)) dut (
    .SC_MAX7219DRIVER_CLOCK_50        (clk),
    .SC_MAX7219DRIVER_RESET_InHigh    (rst),
    .SC_MAX7219DRIVER_dispData_InBUS  (data),
    .SC_MAX7219DRIVER_intensity_InBUS (inten),
    .SC_MAX7219DRIVER_dispAddr_OutBUS (addr),
    .SC_MAX7219DRIVER_din_Out         (din),
    .SC_MAX7219DRIVER_ncs_Out         (ncs),
    .SC_MAX7219DRIVER_sclk_Out        (sclk),
    .SC_MAX7219DRIVER_initDone_Out    (idone),
    .SC_MAX7219DRIVER_frameDone_Out   (fdone)
  );

  sc_max7219_driver #(.CLKDIV(25), .DATAWIDTH_BUS(8)) dut25 (
    .SC_MAX7219DRIVER_CLOCK_50        (clk),
    .SC_MAX7219DRIVER_RESET_InHigh    (rst25),
    .SC_MAX7219DRIVER_dispData_InBUS  (8'h5A),
    .SC_MAX7219DRIVER_intensity_InBUS (4'h7),
    .SC_MAX7219DRIVER_dispAddr_OutBUS (addr25),
    .SC_MAX7219DRIVER_din_Out         (din25),
    .SC_MAX7219DRIVER_ncs_Out         (ncs25),
    .SC_MAX7219DRIVER_sclk_Out        (sclk25),
    .SC_MAX7219DRIVER_initDone_Out    (idone25),
    .SC_MAX7219DRIVER_frameDone_Out   (fd25)
  );

  // Serial decoder: only complete 16-bit frames become words.
  always @(posedge sclk or posedge ncs) begin
    if (ncs) begin
      if (nb == 16) got_q.push_back(sh);
      nb = 0;
    end else begin
      sh = {sh[14:0], din};
      nb = nb + 1;
    end
  end

  task automatic wait_word(output bit ok, output logic [15:0] w);
    ok = 1'b0;
    w  = 16'd0;
    for (int i = 0; i < 300; i++) begin
      if (got_q.size() > 0) begin
        w  = got_q.pop_front();
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic push_init(logic [3:0] it);
    exp_q.push_back(16'h0C01);
    exp_q.push_back(16'h0900);
    exp_q.push_back(16'h0B07);
    exp_q.push_back({8'h0A, 4'h0, it});
    exp_q.push_back(16'h0F00);
  endtask

  task automatic push_frame(int p, logic [3:0] it);
    for (int k = 0; k < 8; k++)
      exp_q.push_back({4'h0, 4'(k + 1), row_pat(p, 3'(k))});
    exp_q.push_back({8'h0A, 4'h0, it});
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (ncs !== 1'b1) begin errors++; $display("FAIL rst_ncs got %b want 1", ncs); end
    checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL rst_sclk got %b want 0", sclk); end
    checks++; if (din !== 1'b0) begin errors++; $display("FAIL rst_din got %b want 0", din); end
    checks++; if (addr !== 3'd0) begin errors++; $display("FAIL rst_addr got %0d want 0", addr); end
    checks++; if (idone !== 1'b0) begin errors++; $display("FAIL rst_initDone got %b want 0", idone); end
    checks++; if (fdone !== 1'b0) begin errors++; $display("FAIL rst_frameDone got %b want 0", fdone); end
  endtask

  task automatic test_init;
    bit ok;
    logic [15:0] w, e;
    int n;
    got_q.delete();
    exp_q.delete();
    push_init(4'hA);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (ncs !== 1'b0) begin errors++; $display("FAIL init_ncs_fall got %b want 0", ncs); end
    for (int i = 0; i < 5; i++) begin
      e = exp_q.pop_front();
      wait_word(ok, w);
      checks++;
      if (!ok) begin errors++; $display("FAIL init_word%0d timeout want %h", i, e); end
      else if (w !== e) begin errors++; $display("FAIL init_word%0d got %h want %h", i, w, e); end
    end
    checks++; if (idone !== 1'b0) begin errors++; $display("FAIL initDone_early got %b want 0", idone); end
    n = 0;
    while (idone !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    checks++; if (n != 2) begin errors++; $display("FAIL initDone_rise got %0d cycles want 2", n); end
  endtask

  task automatic test_frame;
    bit ok;
    logic [15:0] w, e;
    int n;
    push_frame(0, 4'hA);
    for (int i = 0; i < 9; i++) begin
      e = exp_q.pop_front();
      wait_word(ok, w);
      checks++;
      if (!ok) begin errors++; $display("FAIL frame_word%0d timeout want %h", i, e); end
      else if (w !== e) begin errors++; $display("FAIL frame_word%0d got %h want %h", i, w, e); end
    end
    // Next frame uses distinct rows through a registered upstream mux.
    pat_sel  = 1;
    reg_mode = 1'b1;
    n = 0;
    while (fdone !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    checks++; if (n != 2) begin errors++; $display("FAIL frameDone_rise got %0d cycles want 2", n); end
    @(negedge clk);
    checks++; if (fdone !== 1'b0) begin errors++; $display("FAIL frameDone_width got %b want 0", fdone); end
  endtask

  task automatic test_latency;
    bit ok;
    logic [15:0] w, e;
    push_frame(1, 4'hA);
    for (int i = 0; i < 9; i++) begin
      e = exp_q.pop_front();
      wait_word(ok, w);
      checks++;
      if (!ok) begin errors++; $display("FAIL lat_word%0d timeout want %h", i, e); end
      else if (w !== e) begin errors++; $display("FAIL lat_word%0d got %h want %h", i, w, e); end
    end
  endtask

  task automatic test_intensity;
    bit ok;
    logic [15:0] w, e;
    push_frame(1, 4'h3);
    for (int i = 0; i < 9; i++) begin
      e = exp_q.pop_front();
      wait_word(ok, w);
      checks++;
      if (!ok) begin errors++; $display("FAIL int_word%0d timeout want %h", i, e); end
      else if (w !== e) begin errors++; $display("FAIL int_word%0d got %h want %h", i, w, e); end
      if (i == 3) inten = 4'h3;
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    logic [15:0] w, e;
    int n;
    n = 0;
    while (!(nb == 8 && sh[7:0] == 8'h04) && n < 2000) begin @(negedge clk); n++; end
    checks++;
    if (n >= 2000) begin errors++; $display("FAIL midrst_find timeout got %0d want <2000", n); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (ncs !== 1'b1) begin errors++; $display("FAIL midrst_ncs got %b want 1", ncs); end
    checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL midrst_sclk got %b want 0", sclk); end
    checks++; if (idone !== 1'b0) begin errors++; $display("FAIL midrst_initDone got %b want 0", idone); end
    rst = 1'b0;
    got_q.delete();
    exp_q.delete();
    push_init(4'h3);
    for (int i = 0; i < 5; i++) begin
      e = exp_q.pop_front();
      wait_word(ok, w);
      checks++;
      if (!ok) begin errors++; $display("FAIL midrst_word%0d timeout want %h", i, e); end
      else if (w !== e) begin errors++; $display("FAIL midrst_word%0d got %h want %h", i, w, e); end
    end
  endtask

  task automatic test_timing;
    logic pn, ps, pd;
    int din_chg, min_setup, bad_din, bad_rise, nh_start, nh_bad, nh_n;
    int nfall, fd_cyc;
    int falls[3];
    pn = 1'b1; ps = 1'b0; pd = 1'b0;
    din_chg = 0; min_setup = 1000000; bad_din = 0; bad_rise = 0;
    nh_start = 0; nh_bad = 0; nh_n = 0; nfall = 0; fd_cyc = -1;
    falls[0] = 0; falls[1] = 0; falls[2] = 0;
    rst25 = 1'b0;
    for (int cyc = 1; cyc <= 12000; cyc++) begin
      @(negedge clk);
      if (din25 !== pd) begin
        din_chg = cyc;
        if (sclk25) bad_din++;
      end
      if (sclk25 && !ps) begin
        if (ncs25) bad_rise++;
        if (cyc - din_chg < min_setup) min_setup = cyc - din_chg;
      end
      if (ncs25 && !pn) nh_start = cyc;
      if (!ncs25 && pn) begin
        if (nfall > 0) begin
          nh_n++;
          if (cyc - nh_start != 25) nh_bad++;
        end
        if (nfall < 3) falls[nfall] = cyc;
        nfall++;
      end
      if (fd25 && fd_cyc < 0) fd_cyc = cyc;
      pn = ncs25; ps = sclk25; pd = din25;
    end
    checks++; if (falls[2] - falls[1] != 851) begin errors++; $display("FAIL word_len got %0d want 851", falls[2] - falls[1]); end
    checks++; if (nh_n == 0 || nh_bad != 0) begin errors++; $display("FAIL ncs_high bad %0d of %0d want 0", nh_bad, nh_n); end
    checks++; if (min_setup < 25) begin errors++; $display("FAIL din_setup got %0d want >=25", min_setup); end
    checks++; if (bad_din != 0) begin errors++; $display("FAIL din_while_high got %0d want 0", bad_din); end
    checks++; if (bad_rise != 0) begin errors++; $display("FAIL rise_ncs_high got %0d want 0", bad_rise); end
    checks++; if (fd_cyc != 11914) begin errors++; $display("FAIL first_frameDone got %0d want 11914", fd_cyc); end
    checks++; if (idone25 !== 1'b1) begin errors++; $display("FAIL initDone25 got %b want 1", idone25); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_frame();
    test_latency();
    test_intensity();
    test_reset_mid();
    test_timing();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
